// File: rtl/preg_free_list.sv
// Physical-register free list: circular FIFO of free tags, one zero-latency
// allocation per cycle and up to two releases from the retire stage.
module preg_free_list #(
  parameter int PREG_WIDTH = 6,
  parameter int NUM_AREG   = 32,
  parameter int NUM_PREG   = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alloc_req,
  output logic                  alloc_grant,
  output logic [PREG_WIDTH-1:0] alloc_tag,
  input  logic                  free0_valid,
  input  logic [PREG_WIDTH-1:0] free0_tag,
  input  logic                  free1_valid,
  input  logic [PREG_WIDTH-1:0] free1_tag,
  output logic                  empty,
  output logic [PREG_WIDTH:0]   free_count,
  output logic                  overflow_err
);
  localparam int DEPTH = NUM_PREG - NUM_AREG;
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = PREG_WIDTH + 1;
  localparam int SW    = CW + 1;
  localparam int NFREE = 2;

  logic [DEPTH-1:0][PREG_WIDTH-1:0] fifo;
  logic [PW-1:0]                    head, tail, tail_nxt;
  logic [CW-1:0]                    cnt, cnt_nxt;
  logic                             ovf;

  logic [NFREE-1:0]                 fv, acc;
  logic [NFREE-1:0][PREG_WIDTH-1:0] ft;
  logic [NFREE-1:0][PW-1:0]         wr_idx;
  logic [SW-1:0]                    space;
  logic                             ovf_set;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign ft[0] = free0_tag;
  assign ft[1] = free1_tag;

  // x0 is hardwired, so a release of tag 0 is silently ignored.
  generate
    for (genvar s = 0; s < NFREE; s++) begin : g_qual
      logic vin;
      assign vin   = (s == 0) ? free0_valid : free1_valid;
      assign fv[s] = vin & (ft[s] != '0);
    end
  endgenerate

  assign empty        = (cnt == '0);
  assign alloc_grant  = alloc_req & ~empty;
  assign alloc_tag    = fifo[head];
  assign free_count   = cnt;
  assign overflow_err = ovf;

  // The slot consumed by this cycle's grant counts as space for frees.
  always_comb begin
    space     = SW'(DEPTH) - SW'(cnt) + SW'(alloc_grant);
    acc[0]    = fv[0] & (space != '0);
    acc[1]    = fv[1] & (space > SW'(acc[0]));
    ovf_set   = |(fv & ~acc);
    wr_idx[0] = tail;
    wr_idx[1] = acc[0] ? ptr_inc(tail) : tail;
    tail_nxt  = tail;
    if (&acc)      tail_nxt = ptr_inc(ptr_inc(tail));
    else if (|acc) tail_nxt = ptr_inc(tail);
    cnt_nxt   = cnt + CW'(acc[0]) + CW'(acc[1]) - CW'(alloc_grant);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      cnt  <= CW'(DEPTH);
      ovf  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) fifo[i] <= PREG_WIDTH'(NUM_AREG + i);
    end else begin
      if (alloc_grant) head <= ptr_inc(head);
      tail <= tail_nxt;
      cnt  <= cnt_nxt;
      if (ovf_set) ovf <= 1'b1;
      for (int i = 0; i < DEPTH; i++)
        for (int s = 0; s < NFREE; s++)
          if (acc[s] && wr_idx[s] == PW'(i)) fifo[i] <= ft[s];
    end
  end
endmodule

// File: tb/tb_preg_free_list.sv
// Randomized and directed checks of preg_free_list against a queue model of
// the free list, compared every cycle plus literal anchor values.
module tb_preg_free_list;
  localparam int DEPTH = 32;

  logic       clk, rst_n;
  logic       alloc_req, alloc_grant;
  logic [5:0] alloc_tag;
  logic       free0_valid, free1_valid;
  logic [5:0] free0_tag, free1_tag;
  logic       empty, overflow_err;
  logic [6:0] free_count;

  preg_free_list dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_req(alloc_req), .alloc_grant(alloc_grant), .alloc_tag(alloc_tag),
    .free0_valid(free0_valid), .free0_tag(free0_tag),
    .free1_valid(free1_valid), .free1_tag(free1_tag),
    .empty(empty), .free_count(free_count), .overflow_err(overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int q[$];
  bit m_ovf;
  bit chk_en = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    for (int i = 0; i < DEPTH; i++) q.push_back(32 + i);
    m_ovf = 0;
  endfunction

  // One clock edge of the free list, from its rules rather than its structure.
  function automatic void model_update();
    bit g;
    int space;
    g = alloc_req && q.size() > 0;
    space = DEPTH - q.size() + (g ? 1 : 0);
    if (g) void'(q.pop_front());
    if (free0_valid && free0_tag != 0) begin
      if (space > 0) begin q.push_back(free0_tag); space--; end
      else m_ovf = 1;
    end
    if (free1_valid && free1_tag != 0) begin
      if (space > 0) begin q.push_back(free1_tag); space--; end
      else m_ovf = 1;
    end
  endfunction

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("empty", empty, q.size() == 0);
      chk("free_count", free_count, q.size());
      chk("overflow_err", overflow_err, m_ovf);
      chk("alloc_grant", alloc_grant, alloc_req && q.size() > 0);
      if (q.size() > 0) chk("alloc_tag", alloc_tag, q[0]);
    end
  end

  // Called just after a posedge: drive, sample mid-cycle, then take the edge.
  task automatic step(input bit req, input bit v0, input int t0,
                      input bit v1, input int t1, output bit g, output int t);
    alloc_req = req; free0_valid = v0; free0_tag = 6'(t0);
    free1_valid = v1; free1_tag = 6'(t1);
    #3;
    g = alloc_grant; t = alloc_tag;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    alloc_req = 0; free0_valid = 0; free1_valid = 0; free0_tag = 0; free1_tag = 0;
  endtask

  // Reset pulse entirely between edges; we are at posedge+1 on entry.
  task automatic reset_pulse();
    #1 rst_n = 0;
    idle_inputs();
    #1 rst_n = 1;
    model_reset();
    #1;
    chk("rst free_count", free_count, 32);
    chk("rst alloc_tag", alloc_tag, 32);
    chk("rst empty", empty, 0);
    chk("rst overflow", overflow_err, 0);
  endtask

  initial begin
    bit g;
    int t;
    rst_n = 0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    reset_pulse();
    chk_en = 1;

    // Drain: tags 32..63 in order, then empty.
    for (int i = 0; i < 32; i++) begin
      step(1, 0, 0, 0, 0, g, t);
      chk("drain grant", g, 1);
      chk("drain tag", t, 32 + i);
    end
    step(1, 0, 0, 0, 0, g, t);
    chk("drained grant", g, 0);
    chk("drained count", free_count, 0);
    chk("drained empty", empty, 1);

    // No bypass from frees into an empty list.
    step(1, 1, 40, 1, 41, g, t);
    chk("bypass grant", g, 0);
    step(1, 0, 0, 0, 0, g, t);
    chk("post-free tag0", t, 40);
    step(1, 0, 0, 0, 0, g, t);
    chk("post-free tag1", t, 41);

    // Full minus one plus an alloc leaves room for two frees.
    reset_pulse();
    step(1, 0, 0, 0, 0, g, t);
    step(1, 1, 50, 1, 51, g, t);
    chk("room grant", g, 1);
    chk("room count", free_count, 32);
    chk("room ovf", overflow_err, 0);

    // Full list drops both frees and latches the error.
    step(0, 1, 45, 1, 46, g, t);
    chk("drop ovf", overflow_err, 1);
    chk("drop count", free_count, 32);
    step(0, 0, 0, 0, 0, g, t);
    chk("sticky ovf", overflow_err, 1);

    // Tag 0 ignored; only 33 lands, at the tail.
    reset_pulse();
    step(1, 0, 0, 0, 0, g, t);
    step(1, 0, 0, 0, 0, g, t);
    step(0, 1, 0, 1, 33, g, t);
    chk("x0 count", free_count, 31);
    chk("x0 ovf", overflow_err, 0);
    for (int i = 0; i < 30; i++) step(1, 0, 0, 0, 0, g, t);
    step(1, 0, 0, 0, 0, g, t);
    chk("x0 tail tag", t, 33);

    // Randomized traffic with shifting alloc/free pressure.
    reset_pulse();
    for (int ph = 0; ph < 8; ph++) begin
      int rp, fp;
      rp = (ph % 4) * 30 + 5;
      fp = 90 - (ph % 4) * 25;
      for (int c = 0; c < 250; c++)
        step($urandom_range(99) < rp, $urandom_range(99) < fp, $urandom_range(63),
             $urandom_range(99) < fp, $urandom_range(63), g, t);
      if (ph == 3) reset_pulse();
    end

    // Wrap-crossing traffic then asynchronous reset mid-cycle.
    for (int c = 0; c < 40; c++)
      step(1, 1, 32 + (c % 32), c[0], 1 + c % 30, g, t);
    alloc_req = 1; free0_valid = 1; free0_tag = 6'd7;
    reset_pulse();
    step(1, 0, 0, 0, 0, g, t);
    chk("post-rst grant tag", t, 32);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/preg_free_list.md
PREG_FREE_LIST -- requirements
Module: preg_free_list

Interface
REQ-001 SHALL have parameter PREG_WIDTH, default 6, physical tag width.
REQ-002 SHALL have parameter NUM_AREG, default 32, architectural register count.
REQ-003 SHALL have parameter NUM_PREG, default 64, physical register count; DEPTH = NUM_PREG-NUM_AREG (32).
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on posedge.
REQ-005 SHALL have port rst_n, input, 1; one clock, reset asynchronous and active-low.
REQ-006 SHALL have port alloc_req, input, 1, rename stage requests one physical tag for rd.
REQ-007 SHALL have port alloc_grant, output, 1, request accepted this cycle.
REQ-008 SHALL have port alloc_tag, output, PREG_WIDTH, tag handed out; valid when alloc_grant=1.
REQ-009 SHALL have port free0_valid, input, 1, retire slot 0 releases a stale tag.
REQ-010 SHALL have port free0_tag, input, PREG_WIDTH, tag released by slot 0.
REQ-011 SHALL have port free1_valid, input, 1, retire slot 1 releases a stale tag.
REQ-012 SHALL have port free1_tag, input, PREG_WIDTH, tag released by slot 1.
REQ-013 SHALL have port empty, output, 1, no tag available.
REQ-014 SHALL have port free_count, output, PREG_WIDTH+1, tags currently held, 0..DEPTH.
REQ-015 SHALL have port overflow_err, output, 1, sticky: a free was dropped.

Function
REQ-016 SHALL store free tags in a DEPTH-entry circular FIFO with head (read) and tail (write) pointers, log2(DEPTH) bits, wrapping DEPTH-1 -> 0.
REQ-017 SHALL drive alloc_tag = fifo[head] combinationally and alloc_grant = alloc_req & ~empty, zero-latency grant.
REQ-018 SHALL advance head by 1 on the posedge where alloc_grant=1; the tag is consumed only then.
REQ-019 SHALL treat a free with tag < NUM_AREG... as valid except tag 0, which SHALL be ignored (x0 never enters the list).
REQ-020 SHALL write accepted free0 at fifo[tail] and accepted free1 at fifo[tail+1] when both are accepted, at fifo[tail] when only free1 is accepted; tail advances by number accepted (0,1,2).
REQ-021 SHALL not bypass: a tag freed in cycle N is allocatable no earlier than cycle N+1; with empty=1, alloc_grant=0 even if frees are present.
REQ-022 SHALL compute space = DEPTH - free_count + alloc_grant; accept free0 if space>=1, then free1 if remaining space>=1; any rejected valid free SHALL set overflow_err.
REQ-023 SHALL update free_count_next = free_count + accepted_frees - alloc_grant every cycle.
REQ-024 SHALL assert empty when free_count==0, combinationally from registered count.
REQ-025 SHALL keep overflow_err set until reset once set.
REQ-026 SHALL not check for duplicate tags; duplicate frees are caller error and are stored as given.

Reset
REQ-027 SHALL, while rst_n=0 regardless of clk, set head=0, tail=0 (wrapped, full), free_count=DEPTH, overflow_err=0, fifo[i]=NUM_AREG+i for i=0..DEPTH-1.
REQ-028 SHALL give reset outputs: empty=0, alloc_tag=NUM_AREG (32), alloc_grant=alloc_req.
REQ-029 SHALL, on reset assertion mid-operation, discard all in-flight allocs/frees that cycle; first post-reset grant returns tag 32.
REQ-030 SHALL require no initial blocks for functional state; reset alone establishes state.

Verification
REQ-031 SHALL cover: reset, alloc_req=1 for 32 cycles -> tags 32,33,...,63 granted in order, then empty=1, free_count=0, alloc_grant=0.
REQ-032 SHALL cover: from empty, free0=40, free1=41 same cycle with alloc_req=1 -> no grant that cycle; next cycle grant tag 40, following cycle 41.
REQ-033 SHALL cover: free_count=31, alloc_req=1 plus free0=50, free1=51 -> both accepted, free_count=32, overflow_err=0.
REQ-034 SHALL cover: free_count=32, no alloc, free0=45, free1=46 -> both dropped, overflow_err=1 and stays 1, free_count=32.
REQ-035 SHALL cover: free0_tag=0 valid, free1=33 valid -> only 33 written at fifo[tail], free_count +1.
REQ-036 SHALL cover: 40 alloc/free cycles crossing pointer wrap, then async rst_n pulse between edges -> free_count=32, alloc_tag=32 immediately.
